// File: rtl/fifo_drain_arbiter_if.sv
// fifo_drain_arbiter_if: source-FIFO pop channel and downstream valid/ready channel of the drain arbiter
//   src_empty/src_error/src_pop_data : per-source FIFO status and POP_DATA (source i at [i*DATA_WIDTH +: DATA_WIDTH])
//   src_pop_req                      : one-hot-or-zero pop strobe towards the FIFOs
//   out_valid/out_ready              : downstream handshake
//   out_data/out_src_id/out_last     : output word, its source index, last-of-burst flag
interface fifo_drain_arbiter_if #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32
);
  logic [N_SRC-1:0]            src_empty;
  logic [N_SRC-1:0]            src_error;
  logic [N_SRC*DATA_WIDTH-1:0] src_pop_data;
  logic [N_SRC-1:0]            src_pop_req;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [2:0]                  out_src_id;
  logic                        out_last;
  modport master (
    input  src_empty, src_error, src_pop_data, out_ready,
    output src_pop_req, out_valid, out_data, out_src_id, out_last
  );
  modport slave (
    output src_empty, src_error, src_pop_data, out_ready,
    input  src_pop_req, out_valid, out_data, out_src_id, out_last
  );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin burst drain of N_SRC FIFOs into one valid/ready channel via a 2-entry tagged buffer
//   clk_i/nreset_i : clock, synchronous active-low reset
//   enable_i       : 1 = grants allowed, 0 = end current grant
//   bus            : FIFO pop channel and downstream channel (master side)
//   grant_id_o     : current or most recently granted source
//   err_sticky_o   : any source error or pop-on-empty seen since reset
module fifo_drain_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST      = 8
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 enable_i,
  fifo_drain_arbiter_if.master bus,
  output logic [2:0]           grant_id_o,
  output logic                 err_sticky_o
);
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t                state_q, state_d;
  logic [2:0]            grant_q, grant_d, next_src, cap_id_q;
  logic [7:0]            cnt_q, cnt_d;
  logic                  infl_q, cap_last_q, rd_q, wr_q, err_q;
  logic                  pop, hs, g_empty, last_pop;
  logic [1:0]            occ_q, credit;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [2:0]            id_q [2];
  logic [1:0]            last_q;
  logic [N_SRC-1:0]      pop_req;
  // descending k so the nearest non-empty source after grant_q wins
  always_comb begin
    g_empty  = 1'b1;
    cap_data = '0;
    next_src = grant_q;
    pop_req  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == 3'(i)) g_empty = bus.src_empty[i];
      if (cap_id_q == 3'(i)) cap_data = bus.src_pop_data[i*DATA_WIDTH +: DATA_WIDTH];
      pop_req[i] = pop && grant_q == 3'(i);
    end
    for (int k = N_SRC; k >= 1; k--)
      for (int i = 0; i < N_SRC; i++)
        if ((int'(grant_q) + k) % N_SRC == i && !bus.src_empty[i]) next_src = 3'(i);
  end
  // a pop may fill the last free slot only if the head leaves in the same cycle
  assign credit   = occ_q + 2'(infl_q);
  assign hs       = bus.out_valid && bus.out_ready;
  assign last_pop = cnt_q == 8'(BURST - 1);
  assign pop      = state_q == S_BURST && enable_i && !g_empty && (credit < 2'd2 || (credit == 2'd2 && hs));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (enable_i && !(&bus.src_empty)) begin
        state_d = S_BURST;
        grant_d = next_src;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 8'(pop);
      if (!enable_i || g_empty || (pop && last_pop)) state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q    <= S_IDLE;
      grant_q    <= 3'(N_SRC - 1);
      cnt_q      <= '0;
      infl_q     <= 1'b0;
      cap_id_q   <= '0;
      cap_last_q <= 1'b0;
      occ_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
      id_q[0]    <= '0;
      id_q[1]    <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      infl_q     <= pop;
      cap_id_q   <= grant_q;
      cap_last_q <= pop && last_pop;
      occ_q      <= occ_q + 2'(infl_q) - 2'(hs);
      rd_q       <= rd_q ^ hs;
      wr_q       <= wr_q ^ infl_q;
      if (infl_q) begin
        data_q[wr_q] <= cap_data;
        id_q[wr_q]   <= cap_id_q;
        last_q[wr_q] <= cap_last_q;
      end
      err_q <= err_q | (|bus.src_error) | (|(pop_req & bus.src_empty));
    end
  end
  assign bus.src_pop_req = pop_req;
  assign bus.out_valid   = occ_q != 2'd0;
  assign bus.out_data    = data_q[rd_q];
  assign bus.out_src_id  = id_q[rd_q];
  assign bus.out_last    = last_q[rd_q];
  assign grant_id_o      = grant_q;
  assign err_sticky_o    = err_q;
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter: randomized and directed bench with a queue-based reference model of the drain arbiter
module tb_fifo_drain_arbiter;
  localparam int N = 4, DW = 32, B = 8;
  logic clk = 1'b0, nreset = 1'b0, enable = 1'b0;
  logic [2:0] grant_id;
  logic err_sticky;
  fifo_drain_arbiter_if #(.N_SRC(N), .DATA_WIDTH(DW)) bus ();
  fifo_drain_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .BURST(B)) dut (
    .clk_i(clk), .nreset_i(nreset), .enable_i(enable), .bus(bus),
    .grant_id_o(grant_id), .err_sticky_o(err_sticky)
  );
  always #5 clk = ~clk;
  typedef struct { logic [DW-1:0] d; int s; bit l; } item_t;
  typedef struct { int s; bit l; } ev_t;
  logic [DW-1:0] fifo [N][$];
  ev_t out_log[$];
  int total = 0, bad = 0, pops = 0;
  logic [N-1:0] popv;
  bit ov;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  task automatic update_empty();
    for (int i = 0; i < N; i++) bus.src_empty[i] = fifo[i].size() == 0;
  endtask
  task automatic push(input int i, input int n);
    repeat (n) fifo[i].push_back($urandom);
    update_empty();
  endtask
  // one cycle: observe at negedge, then play the FIFOs' side of the edge
  task automatic tick();
    @(negedge clk);
    popv = bus.src_pop_req;
    ov = bus.out_valid;
    if (bus.out_valid && bus.out_ready) out_log.push_back('{int'(bus.out_src_id), bus.out_last});
    pops += $countones(popv);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (popv[i] && fifo[i].size() > 0) bus.src_pop_data[i*DW +: DW] = fifo[i].pop_front();
    update_empty();
  endtask
  task automatic drain(input string name);
    int n;
    enable = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (n < 400 && !(fifo[0].size() == 0 && fifo[1].size() == 0 && fifo[2].size() == 0 &&
                        fifo[3].size() == 0 && !bus.out_valid)) begin
      tick();
      n++;
    end
    chk(name, n < 400, 1);
  endtask
  // reference model: buffer and in-flight pops as queues, grant/burst from the round-robin rules
  bit armed = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  int m_grant = N - 1, m_cnt = 0, cr, s;
  item_t m_pipe[$], m_buf[$], it;
  bit ev, hs, ge, ep;
  logic [N-1:0] epv;
  always @(negedge clk) begin
    if (armed) begin
      ev  = m_buf.size() > 0;
      hs  = ev && bus.out_ready;
      ge  = fifo[m_grant].size() == 0;
      cr  = m_buf.size() + m_pipe.size();
      ep  = m_busy && enable && !ge && (cr < 2 || (cr == 2 && hs));
      epv = '0;
      if (ep) epv[m_grant] = 1'b1;
      chk("pop_req", bus.src_pop_req, epv);
      chk("pop_on_empty", bus.src_pop_req & bus.src_empty, 0);
      chk("out_valid", bus.out_valid, ev);
      if (ev) begin
        chk("out_data", bus.out_data, m_buf[0].d);
        chk("out_src_id", bus.out_src_id, m_buf[0].s);
        chk("out_last", bus.out_last, m_buf[0].l);
      end
      chk("grant_id", grant_id, m_grant);
      chk("err_sticky", err_sticky, m_err);
      if (hs) void'(m_buf.pop_front());
      if (m_pipe.size() > 0) m_buf.push_back(m_pipe.pop_front());
      if (ep) begin
        m_cnt++;
        it.d = fifo[m_grant][0];
        it.s = m_grant;
        it.l = m_cnt == B;
        m_pipe.push_back(it);
      end
      m_err = m_err | (|bus.src_error);
      if (m_busy) begin
        if (!enable || ge || (ep && m_cnt == B)) m_busy = 1'b0;
      end else if (enable) begin
        for (int k = 1; k <= N; k++) begin
          s = (m_grant + k) % N;
          if (!m_busy && fifo[s].size() > 0) begin
            m_grant = s;
            m_busy  = 1'b1;
            m_cnt   = 0;
          end
        end
      end
    end
    if (!nreset) begin
      m_busy = 1'b0;
      m_grant = N - 1;
      m_cnt = 0;
      m_err = 1'b0;
      m_pipe.delete();
      m_buf.delete();
      armed = 1'b1;
    end
  end
  int pexp[7] = '{0, 1, 1, 1, 0, 0, 0};
  int vexp[7] = '{0, 0, 0, 1, 1, 1, 0};
  int rsrc[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
  int rlen[12] = '{8, 8, 8, 8, 8, 8, 8, 8, 4, 4, 4, 4};
  initial begin
    int n, nlast;
    int run_s[$], run_l[$];
    bus.src_empty = '1;
    bus.src_error = '0;
    bus.src_pop_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_pop_req", bus.src_pop_req, 0);
    chk("rst_grant_id", grant_id, 3);
    chk("rst_err", err_sticky, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_src_last", {bus.out_src_id, bus.out_last}, 0);
    nreset = 1'b1;
    // single source, three words
    enable = 1'b1;
    bus.out_ready = 1'b1;
    push(0, 3);
    for (int j = 0; j < 7; j++) begin
      tick();
      chk("t1_pop_seq", popv, pexp[j]);
      chk("t1_valid_seq", ov, vexp[j]);
    end
    // four sources, twenty words each
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    out_log.delete();
    for (int i = 0; i < N; i++) push(i, 20);
    n = 0;
    while (n < 300 && out_log.size() < 80) begin tick(); n++; end
    chk("t2_words", out_log.size(), 80);
    nlast = 0;
    foreach (out_log[j]) begin
      if (out_log[j].l) nlast++;
      if (j == 0 || out_log[j].s != out_log[j-1].s) begin
        run_s.push_back(out_log[j].s);
        run_l.push_back(1);
      end else run_l[run_l.size()-1]++;
    end
    chk("t2_last_count", nlast, 8);
    chk("t2_runs", run_s.size(), 12);
    for (int j = 0; j < 12 && j < run_s.size(); j++) begin
      chk("t2_grant_order", run_s[j], rsrc[j]);
      chk("t2_burst_len", run_l[j], rlen[j]);
    end
    // backpressure mid-burst
    out_log.delete();
    push(1, 16);
    repeat (4) tick();
    bus.out_ready = 1'b0;
    pops = 0;
    repeat (10) tick();
    chk("t3_stall_pops_le2", pops <= 2, 1);
    bus.out_ready = 1'b1;
    n = 0;
    while (n < 100 && out_log.size() < 16) begin tick(); n++; end
    chk("t3_words", out_log.size(), 16);
    // enable dropped after the third pop of a burst
    out_log.delete();
    push(2, 10);
    pops = 0;
    n = 0;
    while (n < 50 && pops < 3) begin tick(); n++; end
    chk("t4_third_pop", pops, 3);
    enable = 1'b0;
    pops = 0;
    repeat (6) tick();
    chk("t4_pops_after", pops, 0);
    chk("t4_words", out_log.size(), 3);
    push(3, 1);
    enable = 1'b1;
    n = 0;
    popv = '0;
    while (n < 20 && popv == 0) begin tick(); n++; end
    chk("t4_next_grant", popv, 4'b1000);
    drain("t4_drain");
    // reset with a full buffer
    push(0, 20);
    push(1, 5);
    bus.out_ready = 1'b0;
    repeat (6) tick();
    nreset = 1'b0;
    tick();
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_pop_req", bus.src_pop_req, 0);
    chk("t5_grant_id", grant_id, 3);
    nreset = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    popv = '0;
    while (n < 20 && popv == 0) begin tick(); n++; end
    chk("t5_first_grant", popv, 4'b0001);
    drain("t5_drain");
    // random traffic
    repeat (3000) begin
      bus.out_ready = $urandom_range(0, 9) < 7;
      enable = $urandom_range(0, 19) != 0;
      nreset = $urandom_range(0, 499) != 0;
      if ($urandom_range(0, 9) == 0) push($urandom_range(0, N - 1), $urandom_range(1, 12));
      tick();
    end
    nreset = 1'b1;
    drain("rand_drain");
    // sticky error
    bus.src_error = 4'b0100;
    tick();
    bus.src_error = '0;
    chk("err_set", err_sticky, 1);
    repeat (5) tick();
    chk("err_hold", err_sticky, 1);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("err_clear", err_sticky, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
